// File: rtl/uart_pkg.sv
// Shared UART constants: state encoding, oversample counts, parity modes.
// Used by both the receiver and the transmitter.
package uart_pkg;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_START  = 3'd1;
   localparam logic [2:0] ST_DATA   = 3'd2;
   localparam logic [2:0] ST_PARITY = 3'd3;
   localparam logic [2:0] ST_STOP   = 3'd4;

   typedef enum logic [2:0] {
      IDLE   = ST_IDLE,
      START  = ST_START,
      DATA   = ST_DATA,
      PARITY = ST_PARITY,
      STOP   = ST_STOP
   } uart_state_t;

   localparam int OVERSAMPLE = 16;
   localparam int MID_TICK   = 7;
   localparam int END_TICK   = 15;

   localparam int PAR_EVEN = 0;
   localparam int PAR_ODD  = 1;

   function automatic logic par_bit(input logic [7:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an async input plus a falling-edge detector.
// All flops reset high so an idle-high line never looks like an edge.
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   output logic rx_s,
   output logic fall
);

   logic meta;
   logic prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta <= 1'b1;
         rx_s <= 1'b1;
         prev <= 1'b1;
      end else begin
         meta <= rx;
         rx_s <= meta;
         prev <= rx_s;
      end
   end

   assign fall = prev & ~rx_s;

endmodule

// File: rtl/uart_rx_parity.sv
// 16x oversampling UART receiver with optional parity check.
// Parity is built only when UART_RX_PARITY_EN is defined.
module uart_rx_parity
   import uart_pkg::*;
#(
   parameter int DBIT       = 8,
   parameter int SB_TICK    = 16,
   parameter int PARITY_ODD = PAR_EVEN
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       s_tick,
   input  logic       rx,
   output logic [7:0] dout,
   output logic       rx_done_tick,
   output logic       parity_err,
   output logic       frame_err
);

   // Tick counter must also reach SB_TICK-1 for 1.5/2 stop bits.
   localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;

   uart_state_t     state;
   logic [SW-1:0]   s;
   logic [2:0]      n;
   logic [DBIT-1:0] b;
   logic            rx_s;
   logic            fall;

   uart_rx_sync u_sync (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .rx_s  (rx_s),
      .fall  (fall)
   );

`ifdef UART_RX_PARITY_EN
   logic p_bit;
   logic par_odd;

   assign par_odd = (PARITY_ODD != 0);
`else
   assign parity_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         s            <= '0;
         n            <= '0;
         b            <= '0;
         dout         <= '0;
         rx_done_tick <= 1'b0;
         frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         p_bit        <= 1'b0;
         parity_err   <= 1'b0;
`endif
      end else begin
         rx_done_tick <= 1'b0;
         unique case (state)
            IDLE: begin
               if (fall) begin
                  state <= START;
                  s     <= '0;
               end
            end
            START: begin
               if (s_tick) begin
                  if (s == SW'(MID_TICK)) begin
                     s <= '0;
                     n <= '0;
                     state <= rx_s ? IDLE : DATA;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            DATA: begin
               if (s_tick) begin
                  if (s == SW'(END_TICK)) begin
                     s <= '0;
                     b <= {rx_s, b[DBIT-1:1]};
                     if (n == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                        state <= PARITY;
`else
                        state <= STOP;
`endif
                     end else begin
                        n <= n + 1'b1;
                     end
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (s_tick) begin
                  if (s == SW'(END_TICK)) begin
                     p_bit <= rx_s;
                     s     <= '0;
                     state <= STOP;
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
`endif
            STOP: begin
               if (s_tick) begin
                  if (s == SW'(SB_TICK - 1)) begin
                     state        <= IDLE;
                     s            <= '0;
                     rx_done_tick <= 1'b1;
                     dout         <= 8'(b);
                     frame_err    <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                     parity_err   <= p_bit ^ par_bit(8'(b), par_odd);
`endif
                  end else begin
                     s <= s + 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_parity.sv
// Scoreboard bench for uart_rx_parity: random and directed frames
// against a frame-level reference model.
module tb_uart_rx_parity;

   localparam int DBIT    = 8;
   localparam int SB_TICK = 16;
   localparam int P_ODD   = 1;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int BIT_CLK = 64;
   // start edge to strobe: half start bit + data + parity + one stop bit
   localparam int LAT = BIT_CLK / 2 + (DBIT + PAR + 1) * BIT_CLK;

   logic       clk;
   logic       reset;
   logic       s_tick;
   logic       rx;
   logic [7:0] dout;
   logic       rx_done_tick;
   logic       parity_err;
   logic       frame_err;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       fe;
      int         t0;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [1:0] tcnt = 2'd0;
   logic [7:0] last_d = 8'h00;
   logic last_pe = 1'b0;
   logic last_fe = 1'b0;

   uart_rx_parity #(
      .DBIT       (DBIT),
      .SB_TICK    (SB_TICK),
      .PARITY_ODD (P_ODD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .s_tick       (s_tick),
      .rx           (rx),
      .dout         (dout),
      .rx_done_tick (rx_done_tick),
      .parity_err   (parity_err),
      .frame_err    (frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc  <= cyc + 1;
      tcnt <= tcnt + 2'd1;
   end
   assign s_tick = (tcnt == 2'd0);

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual %0h required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rx_done_tick) begin
         if (q.size() == 0) begin
            check("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            exp_t e;
            int lat;
            e = q.pop_front();
            lat = cyc - e.t0;
            check("dout", 32'(dout), 32'(e.d));
            check("parity_err", 32'(parity_err), 32'(e.pe));
            check("frame_err", 32'(frame_err), 32'(e.fe));
            checks++;
            if (lat < LAT - 2 || lat > LAT + 6) begin
               errors++;
               $display("FAIL latency actual %0d required %0d..%0d",
                        lat, LAT - 2, LAT + 6);
            end
         end
      end
   end

   task automatic hold(input logic v, input int clks);
      rx = v;
      repeat (clks) @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] dmask(input logic [7:0] d);
      logic [7:0] m;
      m = 8'((1 << DBIT) - 1);
      return d & m;
   endfunction

   function automatic logic good_par(input logic [7:0] d);
      return ((^dmask(d)) ? 1'b1 : 1'b0) ^ (P_ODD != 0);
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic pb,
                             input logic sb, input bit keep_low);
      exp_t e;
      e.d  = dmask(d);
      e.pe = (PAR != 0) ? (pb != good_par(d)) : 1'b0;
      e.fe = ~sb;
      e.t0 = cyc;
      q.push_back(e);
      last_d  = e.d;
      last_pe = e.pe;
      last_fe = e.fe;
      hold(1'b0, BIT_CLK);
      for (int i = 0; i < DBIT; i++) hold(d[i], BIT_CLK);
      if (PAR != 0) hold(pb, BIT_CLK);
      hold(sb, BIT_CLK);
      if (!keep_low) hold(1'b1, BIT_CLK);
   endtask

   initial begin
      reset = 1'b1;
      rx    = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_dout", 32'(dout), 32'h0);
      check("reset_done", 32'(rx_done_tick), 32'h0);
      check("reset_perr", 32'(parity_err), 32'h0);
      check("reset_ferr", 32'(frame_err), 32'h0);
      @(posedge clk);
      #1;
      hold(1'b1, BIT_CLK);

      send_frame(8'hA5, good_par(8'hA5), 1'b1, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b1, 1'b0);

      // framing error, then a held-low line must not retrigger
      send_frame(8'h55, good_par(8'h55), 1'b0, 1'b1);
      hold(1'b0, 4 * BIT_CLK);
      hold(1'b1, 2 * BIT_CLK);

      // short low pulse is a glitch
      hold(1'b0, 16);
      hold(1'b1, 3 * BIT_CLK);
      check("glitch_dout", 32'(dout), 32'(last_d));
      check("glitch_perr", 32'(parity_err), 32'(last_pe));
      check("glitch_ferr", 32'(frame_err), 32'(last_fe));

      // reset during data bit 3 of 0xFF
      hold(1'b0, BIT_CLK);
      for (int i = 0; i < 3; i++) hold(1'b1, BIT_CLK);
      hold(1'b1, BIT_CLK / 2);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("midrst_dout", 32'(dout), 32'h0);
      check("midrst_perr", 32'(parity_err), 32'h0);
      check("midrst_ferr", 32'(frame_err), 32'h0);
      @(posedge clk);
      #1;
      hold(1'b1, 6 * BIT_CLK);
      check("midrst_queue", 32'(q.size()), 32'h0);
      send_frame(8'h81, good_par(8'h81), 1'b1, 1'b0);

      for (int k = 0; k < 24; k++) begin
         logic [7:0] d;
         logic pb;
         logic sb;
         d  = 8'($urandom);
         pb = good_par(d) ^ ($urandom_range(0, 3) == 0);
         sb = ($urandom_range(0, 6) != 0);
         send_frame(d, pb, sb, 1'b0);
      end

      hold(1'b1, 2 * BIT_CLK);
      check("queue_empty", 32'(q.size()), 32'h0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
